// File: rtl/conv3_pkg.sv
// conv3_pkg: FSM state encoding, default memory map and sizing helper shared
// by the conv3 host sequencer and its sub-modules.
package conv3_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_KER,
        LOAD_IMG,
        CLR,
        GO,
        POLL,
        RD_REQ,
        RD_WAIT,
        OUT,
        DONE
    } conv3_state_e;

    localparam logic [13:0] KER_BASE_DEF  = 14'h003F;
    localparam logic [13:0] IMG_BASE_DEF  = 14'h0000;
    localparam logic [13:0] RES_BASE_DEF  = 14'h0041;
    localparam logic [13:0] CLR_ADDR_DEF  = 14'h3FFD;
    localparam logic [13:0] GO_ADDR_DEF   = 14'h3FFE;
    localparam logic [13:0] STAT_ADDR_DEF = 14'h3FFF;

    // Largest of three word counts; sizes the shared word counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/conv3_out_skid.sv
// conv3_out_skid: one-entry holding register driving the result stream.
// Data is frozen while m_valid is high and m_ready is low.
module conv3_out_skid #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    // Capture a word on load, release it on the accepting handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv3_host_sequencer.sv
// conv3_host_sequencer: streams kernel and image words into the convolution
// memory, kicks the engine, polls its status word and streams results out.
// Optional macro CONV3_SEQ_TIMEOUT_EN bounds the status poll by POLL_LIMIT cycles.
module conv3_host_sequencer
    import conv3_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned KER_WORDS = 2,
    parameter int unsigned IMG_WORDS = 9,
    parameter int unsigned RES_WORDS = 8,
    parameter logic [ADDR_W-1:0] KER_BASE  = ADDR_W'(KER_BASE_DEF),
    parameter logic [ADDR_W-1:0] IMG_BASE  = ADDR_W'(IMG_BASE_DEF),
    parameter logic [ADDR_W-1:0] RES_BASE  = ADDR_W'(RES_BASE_DEF),
    parameter logic [ADDR_W-1:0] CLR_ADDR  = ADDR_W'(CLR_ADDR_DEF),
    parameter logic [ADDR_W-1:0] GO_ADDR   = ADDR_W'(GO_ADDR_DEF),
`ifdef CONV3_SEQ_TIMEOUT_EN
    parameter int unsigned POLL_LIMIT = 65535,
`endif
    parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(STAT_ADDR_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              o_we,
    output logic              o_re,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata
);

    localparam int unsigned CNT_W = $clog2(max3(KER_WORDS, IMG_WORDS, RES_WORDS) + 1);

    conv3_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             skid_load;

`ifdef CONV3_SEQ_TIMEOUT_EN
    localparam int unsigned PCNT_W = $clog2(POLL_LIMIT + 1);

    logic [PCNT_W-1:0] poll_cnt_q;
    logic              timeout_q;
    logic              poll_expired;

    assign poll_expired = (poll_cnt_q == PCNT_W'(POLL_LIMIT - 1));

    // Poll-cycle counter and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            poll_cnt_q <= (state_q == POLL) ? poll_cnt_q + PCNT_W'(1) : '0;
            if ((state_q == POLL) && (state_d == DONE)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    // State, word counter and poll-response-valid flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Next-state and memory/stream strobes; strobes are same-cycle with the handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        s_ready      = 1'b0;
        o_we         = 1'b0;
        o_re         = 1'b0;
        o_write_addr = '0;
        o_read_addr  = '0;
        o_wdata      = '0;
        o_done       = 1'b0;
        skid_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD_KER;
                    cnt_d   = '0;
                end
            end
            LOAD_KER: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    o_we         = 1'b1;
                    o_wdata      = s_data;
                    o_write_addr = KER_BASE + ADDR_W'(cnt_q);
                    if (cnt_q == CNT_W'(KER_WORDS - 1)) begin
                        state_d = LOAD_IMG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_IMG: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    o_we         = 1'b1;
                    o_wdata      = s_data;
                    o_write_addr = IMG_BASE + ADDR_W'(cnt_q);
                    if (cnt_q == CNT_W'(IMG_WORDS - 1)) begin
                        state_d = CLR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CLR: begin
                o_we         = 1'b1;
                o_write_addr = CLR_ADDR;
                state_d      = GO;
            end
            GO: begin
                o_we         = 1'b1;
                o_write_addr = GO_ADDR;
                o_wdata      = DATA_W'(1);
                armed_d      = 1'b0;
                state_d      = POLL;
            end
            POLL: begin
                // First POLL cycle only launches the read; later cycles see a valid response.
                o_re        = 1'b1;
                o_read_addr = STAT_ADDR;
                armed_d     = 1'b1;
                if (armed_q && (i_rdata == DATA_W'(1))) begin
                    state_d = RD_REQ;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
`ifdef CONV3_SEQ_TIMEOUT_EN
                else if (poll_expired) begin
                    state_d = DONE;
                    armed_d = 1'b0;
                end
`endif
            end
            RD_REQ: begin
                o_re        = 1'b1;
                o_read_addr = RES_BASE + ADDR_W'(cnt_q);
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                skid_load = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_valid && m_ready) begin
                    if (cnt_q == CNT_W'(RES_WORDS - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy = (state_q != IDLE);

    // Result holding register and output handshake.
    conv3_out_skid #(
        .DATA_W (DATA_W)
    ) u_out_skid (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .load      (skid_load),
        .load_data (i_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
    );

endmodule

// File: tb/tb_conv3_host_sequencer.sv
// tb_conv3_host_sequencer: scoreboard bench for the conv3 host sequencer.
// Stimulus pushes expected writes/reads/results into queues; a monitor pops
// and compares whenever the DUT strobes memory or hands off a result.
// Build with +define+CONV3_SEQ_TIMEOUT_EN to also exercise the poll timeout.
module tb_conv3_host_sequencer;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        o_busy, o_done, o_timeout;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic        o_we, o_re;
    logic [13:0] o_write_addr, o_read_addr;
    logic [31:0] o_wdata;
    logic [31:0] i_rdata;

    int n_vec = 0;
    int n_err = 0;

    wr_t         exp_wr[$];
    logic [13:0] exp_rd[$];
    logic [31:0] exp_res[$];
    logic [31:0] src_q[$];

    bit src_toggle   = 1'b0;
    int status_delay = 0;
    int stall_idx    = -1;
    int stall_left   = 0;
    int rx_cnt       = 0;
    int done_cnt     = 0;
    int mv_cycles    = 0;

    conv3_host_sequencer #(
`ifdef CONV3_SEQ_TIMEOUT_EN
        .POLL_LIMIT (100),
`endif
        .ADDR_W     (14)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .o_we         (o_we),
        .o_re         (o_re),
        .o_write_addr (o_write_addr),
        .o_read_addr  (o_read_addr),
        .o_wdata      (o_wdata),
        .i_rdata      (i_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({o_busy, o_done, o_timeout, s_ready, m_valid, o_we, o_re,
                    |o_write_addr, |o_read_addr, |o_wdata, |m_data});
    endfunction

    // Memory model: status word goes to 1 status_delay cycles after the GO write.
    bit go_seen = 1'b0;
    int st_cnt  = 0;
    always @(posedge i_clk) begin
        if (o_re) begin
            if (o_read_addr == 14'h3FFF)
                i_rdata <= (go_seen && st_cnt >= status_delay) ? 32'd1 : 32'd0;
            else
                i_rdata <= 32'hC0DE_0000 | 32'(o_read_addr);
        end else begin
            i_rdata <= 32'hDEAD_BEEF;
        end
        if (o_we && o_write_addr == 14'h3FFD) go_seen <= 1'b0;
        if (o_we && o_write_addr == 14'h3FFE) begin
            go_seen <= 1'b1;
            st_cnt  <= 0;
        end else begin
            st_cnt <= st_cnt + 1;
        end
    end

    // Input stream source: presents queued words, optionally every other cycle.
    initial begin
        bit tog = 1'b0;
        bit hs  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge i_clk);
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && (!src_toggle || tog)) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
            tog = ~tog;
            #1;
            hs = s_valid && s_ready;
        end
    end

    // Result sink and monitor/scoreboard.
    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] held       = '0;
        wr_t         w;
        logic [13:0] ra;
        logic [31:0] rd;
        m_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            if (m_valid && rx_cnt == stall_idx && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
            end
            #1;
            if (o_we || o_re) check("we_re_exclusive", 64'(o_we && o_re), 64'd0);
            if (o_we) begin
                check("write_expected", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("write_addr_data", {18'd0, o_write_addr, o_wdata}, {18'd0, w.a, w.d});
                end
            end
            if (o_re && o_read_addr != 14'h3FFF) begin
                check("read_expected", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) begin
                    ra = exp_rd.pop_front();
                    check("read_addr", 64'(o_read_addr), 64'(ra));
                end
            end
            if (prev_stall && m_valid) check("m_data_stable", 64'(m_data), 64'(held));
            if (m_valid && !m_ready) begin
                check("no_read_during_stall", 64'(o_re), 64'd0);
                held       = m_data;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (m_valid) mv_cycles++;
            if (m_valid && m_ready) begin
                check("result_expected", 64'(exp_res.size() > 0), 64'd1);
                if (exp_res.size() > 0) begin
                    rd = exp_res.pop_front();
                    check("result_data", 64'(m_data), 64'(rd));
                end
                rx_cnt++;
            end
            if (o_done) done_cnt++;
        end
    end

    // Queue one job: kernel 0x12345678/0x90000000, nine image words seed+i.
    task automatic push_job(input logic [31:0] seed, input bit with_results);
        src_q.push_back(32'h1234_5678);
        src_q.push_back(32'h9000_0000);
        exp_wr.push_back('{a: 14'h003F, d: 32'h1234_5678});
        exp_wr.push_back('{a: 14'h0040, d: 32'h9000_0000});
        for (int i = 0; i < 9; i++) begin
            src_q.push_back(seed + 32'(i));
            exp_wr.push_back('{a: 14'(i), d: seed + 32'(i)});
        end
        exp_wr.push_back('{a: 14'h3FFD, d: 32'h0});
        exp_wr.push_back('{a: 14'h3FFE, d: 32'h1});
        if (with_results) begin
            for (int k = 0; k < 8; k++) begin
                exp_rd.push_back(14'h0041 + 14'(k));
                exp_res.push_back(32'hC0DE_0041 + 32'(k));
            end
        end
        rx_cnt = 0;
    endtask

    // Start a job and wait (bounded) for o_done; lat counts cycles from accept.
    task automatic run_to_done(input int extra_start_at, output int lat);
        int d0;
        d0 = done_cnt;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        #2;
        lat = 1;
        while (done_cnt == d0 && lat < 3000) begin
            @(negedge i_clk);
            #2;
            lat++;
            i_start = (lat == extra_start_at);
        end
        i_start = 1'b0;
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic job_end_checks(input bit exp_timeout);
        int d1;
        d1 = done_cnt;
        repeat (4) @(negedge i_clk);
        #2;
        check("single_done", 64'(done_cnt - d1), 64'd0);
        check("idle_after_job", 64'(o_busy), 64'd0);
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        check("reads_drained", 64'(exp_rd.size()), 64'd0);
        check("results_drained", 64'(exp_res.size()), 64'd0);
        check("source_drained", 64'(src_q.size()), 64'd0);
        check("timeout_flag", 64'(o_timeout), 64'(exp_timeout));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  found;
        i_rst   = 1'b1;
        i_start = 1'b0;
        #3;
        check("reset_outputs", outs_vec(), 64'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #2;
        check("idle_outputs", outs_vec(), 64'd0);

        // Continuous stream, status after 50 cycles.
        status_delay = 50;
        push_job(32'hA000_0000, 1'b1);
        run_to_done(0, lat);
        job_end_checks(1'b0);

        // No stalls, status 1 at first check: minimum latency 2+9+2+2+24+1.
        status_delay = 0;
        push_job(32'hB000_0000, 1'b1);
        run_to_done(0, lat);
        check("min_latency", 64'(lat), 64'd40);
        job_end_checks(1'b0);

        // s_valid every other cycle.
        src_toggle   = 1'b1;
        status_delay = 5;
        push_job(32'hC000_0000, 1'b1);
        run_to_done(0, lat);
        job_end_checks(1'b0);
        src_toggle = 1'b0;

        // m_ready low for 20 cycles on result index 3.
        push_job(32'hD000_0000, 1'b1);
        stall_idx  = 3;
        stall_left = 20;
        run_to_done(0, lat);
        check("stall_consumed", 64'(stall_left), 64'd0);
        job_end_checks(1'b0);
        stall_idx = -1;

        // Reset while polling, then a fresh job.
        status_delay = 1_000_000;
        push_job(32'hE000_0000, 1'b1);
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge i_clk);
            #2;
            found = o_re && (o_read_addr == 14'h3FFF);
        end
        check("poll_reached", 64'(found), 64'd1);
        i_rst = 1'b1;
        #1;
        check("reset_in_poll_outputs", outs_vec(), 64'd0);
        @(posedge i_clk);
        #1;
        check("reset_held_outputs", outs_vec(), 64'd0);
        check("writes_before_poll", 64'(exp_wr.size()), 64'd0);
        exp_rd.delete();
        exp_res.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        status_delay = 10;
        push_job(32'hF000_0000, 1'b1);
        run_to_done(0, lat);
        job_end_checks(1'b0);

        // i_start pulsed in LOAD_IMG (cycle 5 after accept) is ignored.
        push_job(32'h5500_0000, 1'b1);
        run_to_done(5, lat);
        job_end_checks(1'b0);

`ifdef CONV3_SEQ_TIMEOUT_EN
        // Status never 1: timeout, done pulse, no results.
        begin
            int mv0;
            mv0          = mv_cycles;
            status_delay = 1_000_000;
            push_job(32'h7700_0000, 1'b0);
            run_to_done(0, lat);
            job_end_checks(1'b1);
            check("no_results_on_timeout", 64'(mv_cycles - mv0), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv3_host_sequencer.md
CONV3_HOST_SEQUENCER -- requirements
Module: conv3_host_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory-interface address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameters KER_WORDS=2, IMG_WORDS=9, RES_WORDS=8, the word counts per job.
REQ-004 SHALL have parameters KER_BASE=14'h3F, IMG_BASE=14'h0, RES_BASE=14'h41, CLR_ADDR=14'h3FFD, GO_ADDR=14'h3FFE, STAT_ADDR=14'h3FFF.
REQ-005 SHALL have ports, one per line:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  job request, sampled in IDLE only.
- o_busy  out  1  high from job accept until return to IDLE.
- o_done  out  1  one-cycle pulse at job end.
- o_timeout  out  1  sticky poll-timeout flag.
- s_valid / s_ready / s_data  in / out / DATA_W  input word stream.
- m_valid / m_ready / m_data  out / in / DATA_W  result word stream.
- o_we, o_re  out  1  write and read strobes to the convolution memory interface.
- o_write_addr, o_read_addr  out  ADDR_W  memory addresses.
- o_wdata  out  DATA_W  write data.
- i_rdata  in  DATA_W  read data, valid one cycle after o_re.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD_KER, LOAD_IMG, CLR, GO, POLL, RD_REQ, RD_WAIT, OUT, DONE.
REQ-007 IDLE: i_start=1 SHALL move to LOAD_KER and clear the word counter; i_start outside IDLE SHALL be ignored.
REQ-008 LOAD_KER/LOAD_IMG: each s_valid&s_ready cycle SHALL produce o_we=1, o_wdata=s_data, o_write_addr=base+count in the same cycle. KER_WORDS words go to KER_BASE, then IMG_WORDS words go to IMG_BASE.
REQ-009 s_ready SHALL be high only in LOAD_KER/LOAD_IMG; s_valid=0 SHALL stall without a write.
REQ-010 CLR SHALL write 0 to CLR_ADDR for one cycle; GO SHALL then write 1 to GO_ADDR for one cycle.
REQ-011 POLL SHALL hold o_re=1 with o_read_addr=STAT_ADDR and examine i_rdata one cycle after the first read. i_rdata==1 SHALL go to RD_REQ; otherwise POLL SHALL continue.
REQ-012 RD_REQ SHALL assert o_re with o_read_addr=RES_BASE+idx. RD_WAIT SHALL capture i_rdata into the output register. OUT SHALL hold m_valid=1 until m_ready.
REQ-013 After the transfer of word RES_WORDS-1, the FSM SHALL go to DONE; otherwise idx+1 and RD_REQ.
REQ-014 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-015 o_we and o_re SHALL never be high together.
REQ-016 m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-017 Counters SHALL be $clog2(max word count + 1) wide. Address add SHALL wrap modulo 2^ADDR_W.
REQ-018 Minimum job latency, start to o_done, SHALL be KER_WORDS+IMG_WORDS+2+2+3*RES_WORDS+1 cycles when streams never stall and status reads 1 at first check.

Reset
REQ-019 i_rst SHALL force IDLE immediately, including mid-job, and clear all counters.
REQ-020 During reset, every output SHALL be 0: o_busy, o_done, o_timeout, s_ready, m_valid, o_we, o_re, all addresses and data.
REQ-021 A job aborted by reset SHALL not resume. Partially written memory is not cleaned up.

Configuration
REQ-022 Macro CONV3_SEQ_TIMEOUT_EN defined: a POLL cycle counter SHALL run against parameter POLL_LIMIT (default 65535). On reaching POLL_LIMIT, o_timeout SHALL set (sticky until reset), a DONE pulse SHALL be issued and no results SHALL be read.
REQ-023 Macro undefined: o_timeout SHALL be tied 0 and POLL SHALL wait indefinitely.

Structure
REQ-024 The state enum and default address constants SHALL live in shared package conv3_pkg.
REQ-025 The result output register and handshake SHALL form sub-module conv3_out_skid (one-entry valid/ready holding register).

Verification
REQ-026 Continuous stream 0x12345678, 0x90000000, then nine image words; model status returns 1 after 50 cycles -> writes to 0x3F, 0x40, 0x0..0x8, 0x3FFD=0, 0x3FFE=1; eight reads 0x41..0x48 emitted in order; one o_done.
REQ-027 s_valid toggled every other cycle -> writes only on handshake cycles, with addresses contiguous.
REQ-028 m_ready held low for 20 cycles on result 3 -> m_data constant, no read to 0x45 until accept.
REQ-029 i_rst asserted in POLL -> all outputs 0 next edge; a new i_start runs a complete job correctly.
REQ-030 With CONV3_SEQ_TIMEOUT_EN and POLL_LIMIT=100, status never 1 -> o_timeout=1, o_done pulse, zero m_valid.
REQ-031 i_start pulsed during LOAD_IMG -> ignored; exactly one job completes.
